// File: rtl/lab9_pio_pkg.sv
// Shared register map for the lab9 SoC PIO slaves: word addresses and STATUS bit positions.
package lab9_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_PERIOD   = 3'd1;
    localparam logic [2:0] ADDR_MASK     = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    localparam int STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/lab9_blink_timer.sv
// Blink phase generator: phase toggles every PERIOD+1 cycles, held high while PERIOD is 0.
// A reload restarts the half-period with phase high on the same edge.
module lab9_blink_timer #(
    parameter int PERIOD_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    input  logic                reload,
    output logic                phase
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (reload || (period == '0)) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == period) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/lab9_soc_led_pio.sv
// Avalon-MM LED output PIO with atomic set/clear; blink engine built only with LAB9_LED_PIO_BLINK_EN.
// Zero wait states, readdata registered one cycle after the address.
module lab9_soc_led_pio
    import lab9_pio_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          PERIOD_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_q, data_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             unused_wd;

    assign wr        = chipselect && !write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    always_comb begin
        data_d = data_q;
        if (wr) begin
            case (address)
                ADDR_DATA:     data_d = wd;
                ADDR_OUTSET:   data_d = data_q | wd;
                ADDR_OUTCLEAR: data_d = data_q & ~wd;
                default:       data_d = data_q;
            endcase
        end
    end

`ifdef LAB9_LED_PIO_BLINK_EN
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic                reload;
    logic                phase;

    assign reload = wr && (address == ADDR_PERIOD);

    always_comb begin
        period_d = period_q;
        mask_d   = mask_q;
        if (reload) begin
            period_d = writedata[PERIOD_W-1:0];
        end
        if (wr && (address == ADDR_MASK)) begin
            mask_d = wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_q <= '0;
            mask_q   <= '0;
        end else begin
            period_q <= period_d;
            mask_q   <= mask_d;
        end
    end

    lab9_blink_timer #(
        .PERIOD_W(PERIOD_W)
    ) u_blink_timer (
        .clk   (clk),
        .reset (reset),
        .period(period_q),
        .reload(reload),
        .phase (phase)
    );

    // Masked bits go dark during the low phase only.
    assign out_port = data_q & ~(mask_q & {WIDTH{~phase}});
`else
    assign out_port = data_q;
`endif

    always_comb begin
        rdata_d = '0;
        case (address)
            ADDR_DATA:   rdata_d[WIDTH-1:0] = data_q;
`ifdef LAB9_LED_PIO_BLINK_EN
            ADDR_PERIOD: rdata_d[PERIOD_W-1:0] = period_q;
            ADDR_MASK:   rdata_d[WIDTH-1:0] = mask_q;
            ADDR_STATUS: rdata_d[STATUS_PHASE_BIT] = phase;
`endif
            default:     rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= RESET_VALUE[WIDTH-1:0];
            rdata_q <= '0;
        end else begin
            data_q  <= data_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata = rdata_q;

endmodule

// File: tb/tb_lab9_soc_led_pio.sv
// Randomised and directed check of lab9_soc_led_pio against a cycle-count based behavioural model.
module tb_lab9_soc_led_pio;

`ifdef LAB9_LED_PIO_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int total = 0;
    int bad   = 0;

    lab9_soc_led_pio #(
        .WIDTH      (8),
        .RESET_VALUE(32'hA5),
        .PERIOD_W   (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    always #5 clk = ~clk;

    // Model state: register contents plus cycles elapsed since the last blink restart.
    logic [7:0]  m_data = 8'h00;
    logic [7:0]  m_mask = 8'h00;
    longint      m_per  = 0;
    longint      m_t    = 0;
    logic [31:0] m_rd   = 32'h0;
    bit          m_vld  = 1'b0;

    function automatic bit m_phase();
        if (!BLINK || m_per == 0) return 1'b1;
        return ((m_t / (m_per + 1)) % 2) == 0;
    endfunction

    function automatic logic [7:0] m_out();
        return m_data & ~(m_mask & (m_phase() ? 8'h00 : 8'hFF));
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {24'h0, m_data};
            3'd1:    return BLINK ? m_per[31:0] : 32'h0;
            3'd2:    return BLINK ? {24'h0, m_mask} : 32'h0;
            3'd3:    return BLINK ? {31'h0, m_phase()} : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step(input bit rst, input bit cs, input bit wn,
                              input logic [2:0] a, input logic [31:0] wd);
        if (rst) begin
            m_data = 8'hA5;
            m_mask = 8'h00;
            m_per  = 0;
            m_t    = 0;
            m_rd   = 32'h0;
            m_vld  = 1'b1;
        end else begin
            m_rd = m_read(a);
            m_t  = m_t + 1;
            if (cs && !wn) begin
                case (a)
                    3'd0: m_data = wd[7:0];
                    3'd1: if (BLINK) begin m_per = longint'(wd); m_t = 0; end
                    3'd2: if (BLINK) m_mask = wd[7:0];
                    3'd4: m_data = m_data | wd[7:0];
                    3'd5: m_data = m_data & ~wd[7:0];
                    default: ;
                endcase
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_vld) begin
            chk("model out_port", {24'h0, out_port}, {24'h0, m_out()});
            chk("model readdata", readdata, m_rd);
        end
    end

    task automatic cyc(input bit rst, input bit cs, input bit wn,
                       input logic [2:0] a, input logic [31:0] wd);
        reset      = rst;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        @(posedge clk);
        model_step(rst, cs, wn, a, wd);
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        cyc(1'b0, 1'b1, 1'b0, a, wd);
    endtask

    task automatic rd(input logic [2:0] a);
        cyc(1'b0, 1'b1, 1'b1, a, 32'h0);
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'h0;
        cyc(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
        chk("reset out_port", {24'h0, out_port}, 32'hA5);
        chk("reset readdata", readdata, 32'h0);
        rd(3'd0);
        chk("read data after reset", readdata, 32'h0000_00A5);

        wr(3'd0, 32'h0F);
        chk("write data", {24'h0, out_port}, 32'h0F);
        wr(3'd4, 32'hF0);
        chk("outset", {24'h0, out_port}, 32'hFF);
        wr(3'd5, 32'h3C);
        chk("outclear", {24'h0, out_port}, 32'hC3);
        rd(3'd4);
        chk("read outset", readdata, 32'h0);

        wr(3'd0, 32'hAA);
        wr(3'd0, 32'h55);
        chk("same-edge read old", readdata, 32'hAA);
        rd(3'd0);
        chk("next read new", readdata, 32'h55);
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'h00);
        chk("cs=0 write ignored", {24'h0, out_port}, 32'h55);
        wr(3'd6, 32'hFF);
        chk("addr6 write ignored", {24'h0, out_port}, 32'h55);
        rd(3'd6);
        chk("addr6 reads 0", readdata, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 32'h11);
        chk("reset beats write", {24'h0, out_port}, 32'hA5);

`ifdef LAB9_LED_PIO_BLINK_EN
        wr(3'd0, 32'hFF);
        wr(3'd2, 32'h01);
        wr(3'd3, 32'h0);
        wr(3'd1, 32'h3);
        chk("blink start", {24'h0, out_port}, 32'hFF);
        for (int i = 1; i < 12; i++) begin
            rd(3'd3);
            chk("blink pattern", {24'h0, out_port}, ((i / 4) % 2) ? 32'hFE : 32'hFF);
        end
        chk("status during high phase", readdata, 32'h1);
        rd(3'd3);
        rd(3'd3);
        rd(3'd3);
        chk("status during low phase", readdata, 32'h0);
        wr(3'd1, 32'h3);
        chk("reload mid-count", {24'h0, out_port}, 32'hFF);
        for (int i = 1; i <= 4; i++) begin
            rd(3'd1);
            chk("after reload", {24'h0, out_port}, (i == 4) ? 32'hFE : 32'hFF);
        end
        chk("period readback", readdata, 32'h3);
`else
        wr(3'd0, 32'h3C);
        wr(3'd1, 32'h5);
        rd(3'd1);
        chk("period unmapped", readdata, 32'h0);
        wr(3'd2, 32'hFF);
        chk("no blink out=data", {24'h0, out_port}, 32'h3C);
`endif

        for (int n = 0; n < 3000; n++) begin
            logic [2:0]  a;
            logic [31:0] d;
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd1) d = ($urandom_range(0, 15) == 0) ? d : 32'($urandom_range(0, 7));
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0, a, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lab9_soc_led_pio.md
Name: lab9_soc_led_pio

Overview:
- Avalon-MM memory-mapped output PIO for the lab9 SoC.
- Write-capable slave that drives board LEDs through out_port.
- Provides atomic bit-set and bit-clear registers, plus a hardware blink engine driven by a programmable cycle prescaler.
- Write-direction counterpart to the SoC's read-only input PIOs. Sits on the same slave fabric with the same zero-wait-state, registered-readdata timing.

Parameters:
- WIDTH, 8: number of output bits on out_port (1..32).
- RESET_VALUE, 0: value loaded into DATA on reset.
- PERIOD_W, 32: width of the PERIOD register and the blink counter (1..32).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  3  word address of the register.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe; a write is accepted when chipselect=1 and write_n=0.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- out_port  output  WIDTH  LED drive.

Behaviour:
- Register map (word addresses):
  - 0 DATA: R/W.
  - 1 PERIOD: R/W.
  - 2 BLINK_MASK: R/W.
  - 3 STATUS: RO; bit0 = phase.
  - 4 OUTSET: WO, reads 0.
  - 5 OUTCLEAR: WO, reads 0.
  - 6, 7: unmapped; read 0, writes ignored.
- Writes: zero wait states, no waitrequest. Only writedata[WIDTH-1:0] is used for DATA and BLINK_MASK, and only [PERIOD_W-1:0] for PERIOD.
- OUTSET: DATA <= DATA | wd. OUTCLEAR: DATA <= DATA & ~wd. Each is single-cycle read-modify-write.
- readdata:
  - Registered every cycle from the address mux, regardless of chipselect; unused upper bits are zero.
  - Value is available one cycle after address is presented.
  - A write and a read-sample on the same edge return the pre-write value. A read of the same address on the following cycle returns the new value.
- Blink engine (counter cnt, phase bit):
  - PERIOD=0: cnt held at 0, phase held at 1.
  - PERIOD=N>0: cnt increments each cycle. When cnt==N, cnt <= 0 and phase toggles. Half-period is therefore N+1 cycles.
  - Any write to PERIOD forces cnt <= 0 and phase <= 1 on the same edge, including a write issued mid-count or a write of the same value.
  - The wrap-around comparison uses equality only. Reloading PERIOD forces cnt to 0, so cnt can never exceed N.
- out_port = DATA & ~(BLINK_MASK & {WIDTH{~phase}}):
  - Combinational from registers, so a write is visible on out_port in the cycle after its accepting edge.
  - Masked bits follow DATA when phase=1 and are forced to 0 when phase=0.
- Reset (synchronous, highest priority over any same-cycle write):
  - DATA=RESET_VALUE, PERIOD=0, BLINK_MASK=0, cnt=0, phase=1, readdata=0.
  - out_port therefore equals RESET_VALUE in the cycle after reset.
  - A reset asserted mid-blink aborts the blink; there is no partial state.

Optional Feature:
- Macro: LAB9_LED_PIO_BLINK_EN.
- Defined: PERIOD, BLINK_MASK, STATUS and the blink engine exist as described above.
- Undefined:
  - No counter or phase logic is synthesised.
  - Addresses 1, 2 and 3 behave as unmapped: read 0, writes ignored.
  - out_port = DATA.
  - DATA, OUTSET and OUTCLEAR behaviour is unchanged.

Decomposition:
- Shared package lab9_pio_pkg holds:
  - Register address constants: ADDR_DATA=0, ADDR_PERIOD=1, ADDR_MASK=2, ADDR_STATUS=3, ADDR_OUTSET=4, ADDR_OUTCLEAR=5.
  - The STATUS bit index.
- One sub-module, lab9_blink_timer, containing the counter, phase and PERIOD-reload logic. It is instantiated only under LAB9_LED_PIO_BLINK_EN. Interface: clk, reset, period, reload, phase.

Test Plan:
- Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5 and readdata=0 the cycle after reset. Read addr 0 -> 32'h000000A5.
- Write DATA=8'h0F, then OUTSET 8'hF0, then OUTCLEAR 8'h3C -> out_port is 8'h0F, 8'hFF, 8'hC3 on successive cycles. Read addr 4 -> 0.
- DATA=8'hFF, BLINK_MASK=8'h01, PERIOD=3 -> out_port alternates 8'hFF and 8'hFE every 4 cycles. STATUS bit0 tracks phase.
- Rewrite PERIOD=3 while phase=0 and cnt=2 -> next cycle phase=1, cnt=0, out_port=8'hFF, and the next toggle occurs 4 cycles later.
- Same-edge write DATA=8'h55 with address=0 (old value 8'hAA) -> readdata=8'hAA next cycle, 8'h55 the cycle after. Write with chipselect=0 or to addr 6 -> no state change.
- Assert reset in the same cycle as a DATA write -> DATA=RESET_VALUE and the write is dropped. Build without LAB9_LED_PIO_BLINK_EN, write addr 1=5 -> read addr 1=0, out_port=DATA.
